sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares the single synchronous data/instruction SRAM port between the instruction-fetch requester and the load/store requester of the CPU. It sits between the fetch stage and the byte-lane/alignment logic of the memory stage on one side, and the SRAM on the other. It issues at most one SRAM access per cycle and routes each read response back to the requester that issued it.

## Interface
Parameters:
- `AW`, 32, address width of all address ports.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  fetch request; held high until `inst_addr_ok`.
- `inst_addr`  in  AW  fetch address, word aligned.
- `inst_addr_ok`  out  1  fetch request granted this cycle.
- `inst_data_ok`  out  1  fetch response valid.
- `inst_rdata`  out  32  fetch data; valid when `inst_data_ok` is high.
- `data_req`  in  1  load/store request; held high until `data_addr_ok`.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_wen`  in  4  byte enables for a store, already lane-shifted.
- `data_addr`  in  AW  load/store address.
- `data_wdata`  in  32  store data, already lane-shifted.
- `data_addr_ok`  out  1  load/store granted this cycle.
- `data_data_ok`  out  1  load/store completed (load data valid).
- `data_rdata`  out  32  raw load word; valid when `data_data_ok` is high.
- `sram_en`  out  1  SRAM access enable.
- `sram_wen`  out  4  SRAM byte write enables.
- `sram_addr`  out  AW  SRAM address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, one cycle after `sram_en`.

## Operation
- Grant is combinational from the current requests and registered state. At most one of `inst_addr_ok`/`data_addr_ok` is high in any cycle.
- Default priority: data over instruction. The instruction port is granted only when `data_req` is low, unless the starvation guard fires (see Configuration).
- On a data grant: `sram_en`=1, `sram_addr`=`data_addr`, `sram_wen`=`data_wr ? data_wen : 4'b0000`, `sram_wdata`=`data_wdata`.
- On an instruction grant: `sram_en`=1, `sram_addr`=`inst_addr`, `sram_wen`=0, `sram_wdata`=0.
- With no grant: `sram_en`=0, `sram_wen`=0. `sram_addr` and `sram_wdata` are 0.
- Response tracking: the registered `resp_sel` has the states RESP_NONE, RESP_INST and RESP_DATA. On each edge it loads the owner of the grant just issued, or RESP_NONE when no grant was issued. Depth is one, which matches the 1-cycle SRAM latency.
- RESP_INST drives `inst_data_ok`=1 and `inst_rdata`=`sram_rdata`.
- RESP_DATA drives `data_data_ok`=1. For a load, `data_rdata`=`sram_rdata`; for a store, `data_rdata` is 0. A registered `resp_wr` bit records load or store.
- Otherwise `*_rdata` are 0.
- Back-to-back grants are allowed every cycle, so a new grant and the previous response coexist in the same cycle.

## Timing
- Reset values:
  - `resp_sel`=RESP_NONE, `resp_wr`=0, `starve_cnt`=0.
  - All `*_ok` outputs are 0 and all `*_rdata` outputs are 0.
  - `sram_en`/`sram_wen` are 0 while `resetn` is low; grants are suppressed during reset.
- Latency: the grant happens in the request cycle when the port wins. `*_data_ok` follows exactly one cycle after `*_addr_ok`.
- Simultaneous `inst_req` and `data_req`: data is granted and the instruction request stays pending, unless the guard selects the instruction port.
- Reset asserted mid-transaction: a pending response is dropped and no `*_data_ok` is issued for it. Requesters re-issue after reset.
- A request may be deasserted only after its `addr_ok`. A request withdrawn before grant is a protocol violation with undefined behaviour.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: a 2-bit `starve_cnt` is compiled in.
  - It increments, saturating at 3, on each data grant issued while `inst_req` is high.
  - It clears on an instruction grant or whenever `inst_req` is low.
  - When `starve_cnt`==3 and `inst_req` is high, the instruction port wins over `data_req` for one grant.
- Macro not defined: strict data priority and no counter logic. Instruction fetch may starve indefinitely.

## Test plan
- Single load: `data_req`=1, `data_wr`=0, `data_addr`=0x100. Expect `data_addr_ok` and `sram_en` with `sram_wen`=0 in cycle 0. In cycle 1, with `sram_rdata`=0xDEADBEEF, expect `data_data_ok`=1 and `data_rdata`=0xDEADBEEF.
- Store: `data_wen`=4'b0100, `data_wdata`=0x00AB0000, addr 0x204. Expect `sram_wen`=4'b0100 and `sram_wdata`=0x00AB0000 in cycle 0, then `data_data_ok`=1 with `data_rdata`=0 in cycle 1.
- Conflict: both requests high in cycle 0. Expect data granted in cycle 0 and the instruction granted in cycle 1. `data_data_ok` is in cycle 1 and `inst_data_ok` in cycle 2, each carrying its own `sram_rdata`.
- Guard (macro on): `inst_req` high and `data_req` high continuously. Expect data grants in cycles 0-2, an instruction grant in cycle 3, then data again. With the macro off, there is no instruction grant in 10 cycles.
- Streaming: fetches to 0x0, 0x4 and 0x8 on consecutive cycles. Expect three consecutive `inst_addr_ok` and `inst_data_ok` in cycles 1-3.
- Reset mid-operation: load granted in cycle 0, `resetn`=0 in cycle 1. Expect `data_data_ok`=0, all outputs 0, and no late response after `resetn` returns high.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between instruction fetch and load/store.
// Optional starvation guard for the fetch port is compiled in with `define ARB_STARVE_GUARD_EN.
module sram_port_arbiter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // instruction fetch requester
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  // load/store requester
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_wen,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  // SRAM port
  output logic          sram_en,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_sel_e;

  resp_sel_e resp_sel, resp_sel_next;
  logic      resp_wr, resp_wr_next;
  logic      grant_inst, grant_data;
  logic      inst_wins;

`ifdef ARB_STARVE_GUARD_EN
  logic [1:0] starve_cnt;

  // Fetch overrides data priority once three data grants have passed it by.
  assign inst_wins = inst_req && (starve_cnt == 2'd3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= 2'd0;
    end else if (grant_inst || !inst_req) begin
      starve_cnt <= 2'd0;
    end else if (grant_data && (starve_cnt != 2'd3)) begin
      starve_cnt <= starve_cnt + 2'd1;
    end
  end
`else
  assign inst_wins = 1'b0;
`endif

  // Grants are gated by resetn so nothing reaches the SRAM while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      if (data_req && !inst_wins) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    if (grant_data) begin
      sram_en    = 1'b1;
      sram_wen   = data_wr ? data_wen : 4'b0000;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  // Response owner for the access issued this cycle; depth one matches the SRAM latency.
  always_comb begin
    resp_sel_next = RESP_NONE;
    resp_wr_next  = 1'b0;
    if (grant_data) begin
      resp_sel_next = RESP_DATA;
      resp_wr_next  = data_wr;
    end else if (grant_inst) begin
      resp_sel_next = RESP_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      resp_sel <= RESP_NONE;
      resp_wr  <= 1'b0;
    end else begin
      resp_sel <= resp_sel_next;
      resp_wr  <= resp_wr_next;
    end
  end

  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    unique case (resp_sel)
      RESP_INST: begin
        inst_data_ok = 1'b1;
        inst_rdata   = sram_rdata;
      end
      RESP_DATA: begin
        data_data_ok = 1'b1;
        data_rdata   = resp_wr ? 32'h0 : sram_rdata;
      end
      default: ;
    endcase
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!resetn)
    !(inst_addr_ok && data_addr_ok));
  a_inst_resp: assert property (@(posedge clk) disable iff (!resetn)
    inst_addr_ok |=> inst_data_ok);
  a_data_resp: assert property (@(posedge clk) disable iff (!resetn)
    data_addr_ok |=> data_data_ok);

endmodule
